// File: rtl/palette_pkg.sv
// Shared definitions for the palette stage (pipe 5).
//   INDEX_W : palette index width (palette holds 2^INDEX_W entries)
//   COLOR_W : RGB word width
//   state_t : producer FSM states
package palette_pkg;

  localparam int INDEX_W = 8;
  localparam int COLOR_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/palette_ram.sv
// Palette RAM: 2^INDEX_W x COLOR_W, one write port and one registered
// read-first read port. Contents are deliberately not reset; the CPU owns them.
//   clk_pipe : clock
//   we       : write strobe, wr_addr / wr_data written at the edge
//   rd_en    : read strobe, rd_data updated at the edge with the OLD
//              contents of rd_addr (read-first on an address collision)
//   rd_data  : registered read data, holds when rd_en=0
module palette_ram #(
  parameter int INDEX_W = 8,
  parameter int COLOR_W = 24
) (
  input  logic               clk_pipe,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [INDEX_W-1:0] rd_addr,
  output logic [COLOR_W-1:0] rd_data
);

  logic [COLOR_W-1:0] mem [2**INDEX_W];

  // Read and write share one process so the read samples mem before the
  // write lands: a same-edge collision returns the old word.
  always_ff @(posedge clk_pipe) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/palette_lookup_writer.sv
// Producer side of the palette FIFO. Accepts palette indices from pipe 4,
// looks them up in the palette RAM and writes RGB words into the clock-
// crossing FIFO, using the FIFO level as credit so no write can be dropped.
//   clk_pipe, reset (async, active-low)
//   enable                     : start/continue streaming; low = drain and stop
//   in_valid/in_index/in_ready : index stream
//   pal_we/pal_addr/pal_data   : CPU palette write port (any state)
//   fifo_size/fifo_full        : FIFO occupancy feedback
//   fifo_write_en/fifo_data    : FIFO write port (data holds when idle)
//   pixel_count/line_done      : position in line, pulse after line wraps
//   busy                       : FSM not IDLE or pixels still in the pipe
//   state_dbg                  : current FSM state
//
// Handshake: a transfer happens on a clk_pipe edge where in_valid and
// in_ready are both 1. in_ready never depends on in_valid; in_valid may be
// raised or dropped freely. The accepted colour reaches the FIFO write port
// exactly two cycles later; the pipeline itself never stalls.
module palette_lookup_writer #(
  parameter int INDEX_W     = palette_pkg::INDEX_W,
  parameter int COLOR_W     = palette_pkg::COLOR_W,
  parameter int LEVEL_W     = 8,
  parameter int HIGH_WATER  = 240,
  parameter int LINE_PIXELS = 1280,
  parameter int PIX_CNT_W   = 11
) (
  input  logic                 clk_pipe,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 in_valid,
  input  logic [INDEX_W-1:0]   in_index,
  output logic                 in_ready,
  input  logic                 pal_we,
  input  logic [INDEX_W-1:0]   pal_addr,
  input  logic [COLOR_W-1:0]   pal_data,
  input  logic [LEVEL_W-1:0]   fifo_size,
  input  logic                 fifo_full,
  output logic                 fifo_write_en,
  output logic [COLOR_W-1:0]   fifo_data,
  output logic [PIX_CNT_W-1:0] pixel_count,
  output logic                 line_done,
  output logic                 busy,
  output palette_pkg::state_t  state_dbg
);

  import palette_pkg::*;

  localparam logic [LEVEL_W:0]   HIGH_WATER_L = (LEVEL_W+1)'(HIGH_WATER);
  localparam logic [PIX_CNT_W-1:0] LAST_PIX   = PIX_CNT_W'(LINE_PIXELS - 1);

  state_t             state_q, state_d;
  logic               s1_valid;
  logic [COLOR_W-1:0] ram_rd_data;
  logic [LEVEL_W:0]   inflight;
  logic [LEVEL_W:0]   credit_sum;
  logic               accept;
  logic               start_line;

  // Pixels already admitted but not yet counted in fifo_size.
  assign inflight   = (LEVEL_W+1)'(s1_valid) + (LEVEL_W+1)'(fifo_write_en);
  assign credit_sum = {1'b0, fifo_size} + inflight;

  assign in_ready   = (state_q == RUN) && !fifo_full && (credit_sum < HIGH_WATER_L);
  assign accept     = in_valid && in_ready;
  assign start_line = (state_q == IDLE) && enable;
  assign busy       = (state_q != IDLE) || s1_valid || fifo_write_en;
  assign state_dbg  = state_q;

  palette_ram #(
    .INDEX_W (INDEX_W),
    .COLOR_W (COLOR_W)
  ) u_ram (
    .clk_pipe (clk_pipe),
    .we       (pal_we),
    .wr_addr  (pal_addr),
    .wr_data  (pal_data),
    .rd_en    (accept),
    .rd_addr  (in_index),
    .rd_data  (ram_rd_data)
  );

  always_ff @(posedge clk_pipe or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // DRAIN has no path back to RUN: the pipe must empty before a restart.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable)                     state_d = RUN;
      RUN:     if (!enable)                    state_d = DRAIN;
      DRAIN:   if (!s1_valid && !fifo_write_en) state_d = IDLE;
      default:                                 state_d = IDLE;
    endcase
  end

  // Stage 1 valid tracks the RAM read; stage 2 is the FIFO write register.
  always_ff @(posedge clk_pipe or negedge reset) begin
    if (!reset) begin
      s1_valid      <= 1'b0;
      fifo_write_en <= 1'b0;
      fifo_data     <= '0;
    end else begin
      s1_valid      <= accept;
      fifo_write_en <= s1_valid;
      if (s1_valid) begin
        fifo_data <= ram_rd_data;
      end
    end
  end

  always_ff @(posedge clk_pipe or negedge reset) begin
    if (!reset) begin
      pixel_count <= '0;
      line_done   <= 1'b0;
    end else begin
      line_done <= 1'b0;
      if (start_line) begin
        pixel_count <= '0;
      end else if (fifo_write_en) begin
        if (pixel_count == LAST_PIX) begin
          pixel_count <= '0;
          line_done   <= 1'b1;
        end else begin
          pixel_count <= pixel_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_palette_lookup_writer.sv
module tb_palette_lookup_writer;
  import palette_pkg::*;

  localparam int HIGH_WATER  = 240;
  localparam int LINE_PIXELS = 4;

  // ---------------- clock / reset ----------------
  logic        clk_pipe = 1'b0;
  logic        reset    = 1'b0;
  logic        enable   = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_index = '0;
  logic        in_ready;
  logic        pal_we   = 1'b0;
  logic [7:0]  pal_addr = '0;
  logic [23:0] pal_data = '0;
  logic [7:0]  fifo_size = '0;
  logic        fifo_full = 1'b0;
  logic        fifo_write_en;
  logic [23:0] fifo_data;
  logic [10:0] pixel_count;
  logic        line_done;
  logic        busy;
  state_t      state_dbg;

  always #5 clk_pipe = ~clk_pipe;

  palette_lookup_writer #(
    .LINE_PIXELS (LINE_PIXELS)
  ) dut (
    .clk_pipe      (clk_pipe),
    .reset         (reset),
    .enable        (enable),
    .in_valid      (in_valid),
    .in_index      (in_index),
    .in_ready      (in_ready),
    .pal_we        (pal_we),
    .pal_addr      (pal_addr),
    .pal_data      (pal_data),
    .fifo_size     (fifo_size),
    .fifo_full     (fifo_full),
    .fifo_write_en (fifo_write_en),
    .fifo_data     (fifo_data),
    .pixel_count   (pixel_count),
    .line_done     (line_done),
    .busy          (busy),
    .state_dbg     (state_dbg)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int writes = 0;
  int ld_pulses = 0;

  logic [23:0] pal_model [256];
  logic [23:0] exp_q[$];
  int          exp_cyc_q[$];
  state_t      m_state = IDLE;
  logic [10:0] m_pc    = '0;
  logic        m_ld    = 1'b0;
  logic [23:0] m_last  = '0;

  always @(posedge clk_pipe) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle monitor: checks outputs mid-cycle, then advances the model.
  always @(negedge clk_pipe) begin
    int          size0;
    logic        exp_rdy;
    logic [23:0] d;
    int          c;
    if (!reset) begin
      check("write_in_reset", fifo_write_en, 0);
      exp_q.delete();
      exp_cyc_q.delete();
      m_state = IDLE;
      m_pc    = '0;
      m_ld    = 1'b0;
      m_last  = '0;
      if (pal_we) pal_model[pal_addr] = pal_data;
    end else begin
      size0   = exp_q.size();
      exp_rdy = (m_state == RUN) && !fifo_full && ((int'(fifo_size) + size0) < HIGH_WATER);
      check("in_ready", in_ready, exp_rdy);
      check("state", state_dbg, m_state);
      check("busy", busy, (m_state != IDLE) || (size0 > 0));
      check("pixel_count", pixel_count, m_pc);
      check("line_done", line_done, m_ld);
      if (line_done) ld_pulses++;
      if (fifo_write_en) begin
        writes++;
        check("write_while_full", fifo_full, 0);
        check("write_expected", fifo_write_en, size0 > 0);
        if (size0 > 0) begin
          d = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("fifo_data", fifo_data, d);
          check("write_latency", cyc, c);
          m_last = d;
        end
      end else begin
        check("fifo_data_hold", fifo_data, m_last);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(pal_model[in_index]);
        exp_cyc_q.push_back(cyc + 2);
      end
      if (pal_we) pal_model[pal_addr] = pal_data;
      if (fifo_write_en) begin
        if (m_pc == 11'(LINE_PIXELS - 1)) begin
          m_pc = '0;
          m_ld = 1'b1;
        end else begin
          m_pc = m_pc + 1'b1;
          m_ld = 1'b0;
        end
      end else begin
        m_ld = 1'b0;
      end
      case (m_state)
        IDLE:    if (enable) begin m_state = RUN; m_pc = '0; end
        RUN:     if (!enable) m_state = DRAIN;
        DRAIN:   if (size0 == 0) m_state = IDLE;
        default: m_state = IDLE;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_pipe);
    #1;
  endtask

  task automatic pal_write(input logic [7:0] a, input logic [23:0] d);
    pal_we   = 1'b1;
    pal_addr = a;
    pal_data = d;
    tick();
    pal_we   = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    check("pipe_drain", exp_q.size(), 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_pipe);
      if (!busy) break;
      tick();
    end
    check("idle_reached", busy, 0);
  endtask

  typedef struct {
    logic [7:0] size;
    logic       full;
    logic       rdy;
  } credit_vec_t;

  credit_vec_t vecs [7];

  // ---------------- test sequence ----------------
  initial begin
    int          w0;
    int          ld0;
    logic [23:0] rnd;

    vecs[0] = '{size: 8'd0,   full: 1'b0, rdy: 1'b1};
    vecs[1] = '{size: 8'd238, full: 1'b0, rdy: 1'b1};
    vecs[2] = '{size: 8'd239, full: 1'b0, rdy: 1'b1};
    vecs[3] = '{size: 8'd240, full: 1'b0, rdy: 1'b0};
    vecs[4] = '{size: 8'd255, full: 1'b0, rdy: 1'b0};
    vecs[5] = '{size: 8'd0,   full: 1'b1, rdy: 1'b0};
    vecs[6] = '{size: 8'd100, full: 1'b1, rdy: 1'b0};

    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_write_en", fifo_write_en, 0);
    check("rst_fifo_data", fifo_data, 0);
    check("rst_pixel_count", pixel_count, 0);
    check("rst_line_done", line_done, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    tick();

    // Load every entry so the model and RAM agree everywhere.
    for (int i = 0; i < 256; i++) begin
      rnd = 24'($urandom_range(0, 32'h00FF_FFFF));
      pal_write(8'(i), rnd);
    end
    pal_write(8'h05, 24'hFF8000);
    pal_write(8'h06, 24'h0000FF);

    enable = 1'b1;
    tick();

    // Back-to-back indices 05, 06.
    in_valid = 1'b1; in_index = 8'h05; tick();
    in_index = 8'h06; tick();
    in_valid = 1'b0;
    wait_empty();

    // Credit table with an empty pipeline.
    for (int i = 0; i < 7; i++) begin
      fifo_size = vecs[i].size;
      fifo_full = vecs[i].full;
      @(negedge clk_pipe);
      check("credit_table", in_ready, vecs[i].rdy);
      tick();
    end
    fifo_size = '0; fifo_full = 1'b0;

    // 239 + one in flight reaches the limit.
    fifo_size = 8'd239;
    in_valid = 1'b1; in_index = 8'h07; tick();
    in_valid = 1'b0;
    @(negedge clk_pipe);
    check("credit_inflight", in_ready, 0);
    tick();
    fifo_size = '0;
    wait_empty();

    // Full FIFO: nothing may be admitted or written.
    w0 = writes;
    fifo_size = 8'd255; fifo_full = 1'b1;
    in_valid = 1'b1; in_index = 8'h05;
    repeat (4) tick();
    in_valid = 1'b0;
    check("no_write_when_full", writes - w0, 0);
    fifo_size = '0; fifo_full = 1'b0;

    // Read-first collision on 0x10, then a fresh read.
    in_valid = 1'b1; in_index = 8'h10;
    pal_we = 1'b1; pal_addr = 8'h10; pal_data = 24'h123456;
    tick();
    pal_we = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_empty();

    // Drop enable with two pixels in flight.
    in_valid = 1'b1; in_index = 8'h05; tick();
    in_index = 8'h06; tick();
    in_valid = 1'b0; enable = 1'b0;
    w0 = writes;
    wait_idle();
    check("drain_writes", writes - w0, 2);

    // Restart clears pixel_count; 5 pixels give one line_done.
    tick();
    enable = 1'b1;
    tick();
    ld0 = ld_pulses;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_index = 8'($urandom_range(0, 255));
      tick();
    end
    in_valid = 1'b0;
    wait_empty();
    tick();
    @(negedge clk_pipe);
    check("line_pulses", ld_pulses - ld0, 1);
    check("pc_after_5", pixel_count, 1);
    tick();

    // Random traffic with palette writes and varying FIFO level.
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_index  = 8'($urandom_range(0, 255));
      fifo_size = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(236, 241))
                                              : 8'($urandom_range(0, 235));
      pal_we    = ($urandom_range(0, 3) == 0);
      pal_addr  = 8'($urandom_range(0, 255));
      pal_data  = 24'($urandom_range(0, 32'h00FF_FFFF));
      tick();
    end
    in_valid = 1'b0; pal_we = 1'b0; fifo_size = '0;
    wait_empty();

    // Reset while s1_valid=1.
    in_valid = 1'b1; in_index = 8'h05; tick();
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("mid_rst_write_en", fifo_write_en, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pixel_count", pixel_count, 0);
    check("mid_rst_line_done", line_done, 0);
    check("mid_rst_fifo_data", fifo_data, 0);
    check("mid_rst_state", state_dbg, IDLE);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    tick();
    // Palette survives reset.
    in_valid = 1'b1; in_index = 8'h05; tick();
    in_index = 8'h06; tick();
    in_index = 8'h10; tick();
    in_valid = 1'b0;
    wait_empty();
    enable = 1'b0;
    wait_idle();

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
